// File: rtl/rr_credit_port_arbiter.sv
// Output-port allocator for the five-port router (L, N, E, W, S).
// One input port owns the output from head flit to tail flit; the next owner
// is chosen round-robin. Every flit is gated on a downstream credit count, and
// a stall watchdog reclaims the port from an owner that stops presenting flits.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no owner; arbitrate among head-flit requesters
// S_GNT_L | L owns the output until its tail transfers
// S_GNT_N | N owns the output until its tail transfers
// S_GNT_E | E owns the output until its tail transfers
// S_GNT_W | W owns the output until its tail transfers
// S_GNT_S | S owns the output until its tail transfers

module rr_credit_port_arbiter #(
   parameter int CREDITS = 4,
   parameter int CW      = 3,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          Lreq,
   input  logic          Nreq,
   input  logic          Ereq,
   input  logic          Wreq,
   input  logic          Sreq,
   input  logic [2:0]    Lflit_id,
   input  logic [2:0]    Nflit_id,
   input  logic [2:0]    Eflit_id,
   input  logic [2:0]    Wflit_id,
   input  logic [2:0]    Sflit_id,
   input  logic          credit_in,
   output logic [5:0]    grant,
   output logic          flit_xfer,
   output logic [CW-1:0] credits,
   output logic          timeout,
   output logic          credit_err
);

   // One-hot encodings double as the crossbar select, so grant is the state itself.
   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_GNT_L = 6'b000010,
      S_GNT_N = 6'b000100,
      S_GNT_E = 6'b001000,
      S_GNT_W = 6'b010000,
      S_GNT_S = 6'b100000
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [7:0]    stall_q;
   logic [CW-1:0] credits_q;
   logic          timeout_q;
   logic          err_q;

   logic [4:0]    req_v, head_v, tail_v, eligible;
   logic          unused_body;
   logic          own_vld;
   logic [2:0]    own_idx;
   logic          cred_nz, xfer, stall, fire;
   logic [3:0]    pick_idle, pick_hand;

   assign req_v  = {Sreq, Wreq, Ereq, Nreq, Lreq};
   assign head_v = {Sflit_id[0], Wflit_id[0], Eflit_id[0], Nflit_id[0], Lflit_id[0]};
   assign tail_v = {Sflit_id[2], Wflit_id[2], Eflit_id[2], Nflit_id[2], Lflit_id[2]};
   // The body bit carries no control meaning: anything without the tail bit moves as body.
   assign unused_body = ^{Sflit_id[1], Wflit_id[1], Eflit_id[1], Nflit_id[1], Lflit_id[1]};

   assign eligible = req_v & head_v;
   assign cred_nz  = (credits_q != '0);

   // First eligible port after base, visiting base itself last; {found, index}.
   function automatic logic [3:0] rr_pick(input logic [2:0] base, input logic [4:0] elig);
      logic [3:0] pick;
      logic [2:0] p;
      pick = 4'b0000;
      for (int k = 5; k >= 1; k--) begin
         p = 3'((int'(base) + k) % 5);
         if (elig[p]) pick = {1'b1, p};
      end
      return pick;
   endfunction

   function automatic state_t port_state(input logic [2:0] idx);
      case (idx)
         3'd0:    return S_GNT_L;
         3'd1:    return S_GNT_N;
         3'd2:    return S_GNT_E;
         3'd3:    return S_GNT_W;
         3'd4:    return S_GNT_S;
         default: return S_IDLE;
      endcase
   endfunction

   // Decode the current owner index from the one-hot grant.
   always_comb begin
      own_vld = 1'b1;
      own_idx = 3'd0;
      case (state_q)
         S_GNT_L: own_idx = 3'd0;
         S_GNT_N: own_idx = 3'd1;
         S_GNT_E: own_idx = 3'd2;
         S_GNT_W: own_idx = 3'd3;
         S_GNT_S: own_idx = 3'd4;
         default: own_vld = 1'b0;
      endcase
   end

   // Reset forces flit_xfer low so a packet abandoned by reset never moves a flit.
   assign xfer      = ~rst & own_vld & req_v[own_idx] & cred_nz;
   assign stall     = own_vld & ~req_v[own_idx] & cred_nz;
   assign fire      = stall & (stall_q == 8'd1);
   assign pick_idle = rr_pick(ptr_q, eligible);
   assign pick_hand = rr_pick(own_idx, eligible);

   // Next state: idle arbitration, direct tail handover, watchdog release.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == S_IDLE) begin
         if (pick_idle[3]) state_d = port_state(pick_idle[2:0]);
      end else if (!own_vld) begin
         state_d = S_IDLE;
      end else if (xfer && tail_v[own_idx]) begin
         ptr_d   = own_idx;
         state_d = pick_hand[3] ? port_state(pick_hand[2:0]) : S_IDLE;
      end else if (fire) begin
         ptr_d   = own_idx;
         state_d = S_IDLE;
      end
   end

   // State register and round-robin pointer; ptr=4 gives L first priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 3'd4;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Stall watchdog as a down-counter of remaining stall cycles; fires on terminal count.
   always_ff @(posedge clk) begin
      if (rst || !own_vld || xfer || fire) begin
         stall_q <= 8'(TIMEOUT);
      end else if (stall) begin
         stall_q <= stall_q - 8'd1;
      end
   end

   // Downstream credit counter with sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q <= CW'(CREDITS);
         err_q     <= 1'b0;
      end else if (xfer && !credit_in) begin
         credits_q <= credits_q - CW'(1);
      end else if (credit_in && !xfer) begin
         if (credits_q == CW'(CREDITS)) err_q <= 1'b1;
         else credits_q <= credits_q + CW'(1);
      end
   end

   // One-cycle timeout pulse, coincident with the forced return to idle.
   always_ff @(posedge clk) begin
      if (rst) timeout_q <= 1'b0;
      else     timeout_q <= fire;
   end

   assign grant      = state_q;
   assign flit_xfer  = xfer;
   assign credits    = credits_q;
   assign timeout    = timeout_q;
   assign credit_err = err_q;

endmodule

// File: tb/tb_rr_credit_port_arbiter.sv
// Bench for rr_credit_port_arbiter: a hand-derived vector table, directed
// multi-cycle sequences, and randomized traffic checked against a
// packet-level reference model.

module tb_rr_credit_port_arbiter;
   localparam int CREDITS = 4;
   localparam int CW      = 3;
   localparam int TIMEOUT = 16;

   logic          clk;
   logic          d_rst;
   logic [4:0]    d_req;
   logic [2:0]    d_fid [5];
   logic          d_cin;
   logic [5:0]    grant;
   logic          flit_xfer;
   logic [CW-1:0] credits;
   logic          timeout;
   logic          credit_err;

   rr_credit_port_arbiter #(.CREDITS(CREDITS), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (d_rst),
      .Lreq       (d_req[0]),
      .Nreq       (d_req[1]),
      .Ereq       (d_req[2]),
      .Wreq       (d_req[3]),
      .Sreq       (d_req[4]),
      .Lflit_id   (d_fid[0]),
      .Nflit_id   (d_fid[1]),
      .Eflit_id   (d_fid[2]),
      .Wflit_id   (d_fid[3]),
      .Sflit_id   (d_fid[4]),
      .credit_in  (d_cin),
      .grant      (grant),
      .flit_xfer  (flit_xfer),
      .credits    (credits),
      .timeout    (timeout),
      .credit_err (credit_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: owner as a port number (-1 = idle), plain integer counters.
   int m_owner, m_ptr, m_cred, m_stall;
   bit m_err, m_to;

   int s_grant, s_cred;
   bit s_xfer, s_to, s_err, mx;

   typedef struct {
      bit         rst;
      logic [4:0] req;
      logic [14:0] fid;   // {S,W,E,N,L} flit ids, 3 bits each
      bit         cin;
      int         g;
      bit         x;
      int         c;
      bit         t;
      bit         e;
   } vec_t;

   vec_t tbl [16];
   logic [2:0] fsel [6];
   logic [2:0] pk [6];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int m_pick(input int base);
      for (int k = 1; k <= 5; k++) begin
         int p;
         p = (base + k) % 5;
         if (d_req[p] && d_fid[p][0]) return p;
      end
      return -1;
   endfunction

   function automatic bit m_xfer_now();
      if (d_rst || m_owner < 0) return 1'b0;
      return d_req[m_owner] && (m_cred != 0);
   endfunction

   function automatic int m_grant();
      return (m_owner < 0) ? 1 : (1 << (m_owner + 1));
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 4; m_cred = CREDITS; m_stall = 0; m_to = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit x, stall_c;
      int own;
      if (d_rst) begin
         model_reset();
         return;
      end
      x = m_xfer_now();
      own = m_owner;
      stall_c = (own >= 0) && !d_req[own] && (m_cred != 0);
      m_to = 0;
      if (x && !d_cin) m_cred--;
      else if (d_cin && !x) begin
         if (m_cred == CREDITS) m_err = 1;
         else m_cred++;
      end
      if (own < 0) begin
         m_stall = 0;
         m_owner = m_pick(m_ptr);
      end else if (x) begin
         m_stall = 0;
         if (d_fid[own][2]) begin
            m_ptr = own;
            m_owner = m_pick(own);
         end
      end else if (stall_c) begin
         m_stall++;
         if (m_stall == TIMEOUT) begin
            m_stall = 0; m_owner = -1; m_ptr = own; m_to = 1;
         end
      end
   endtask

   // Sample at the falling edge, optionally compare to the model, then advance.
   task automatic cycle(input bit chk, input string tag);
      @(negedge clk);
      s_grant = int'(grant);
      s_xfer  = flit_xfer;
      s_cred  = int'(credits);
      s_to    = timeout;
      s_err   = credit_err;
      mx      = m_xfer_now();
      if (chk) begin
         check({tag, ".grant"},      s_grant,      m_grant());
         check({tag, ".flit_xfer"},  int'(s_xfer), int'(mx));
         check({tag, ".credits"},    s_cred,       m_cred);
         check({tag, ".timeout"},    int'(s_to),   int'(m_to));
         check({tag, ".credit_err"}, int'(s_err),  int'(m_err));
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_in();
      d_rst = 1'b0; d_req = '0; d_cin = 1'b0;
      for (int p = 0; p < 5; p++) d_fid[p] = 3'b000;
   endtask

   task automatic do_reset();
      clear_in();
      d_rst = 1'b1;
      cycle(1'b0, "rst");
      cycle(1'b0, "rst");
      d_rst = 1'b0;
   endtask

   function automatic vec_t mk(bit r, logic [4:0] q, logic [14:0] f, bit ci,
                               int g, bit x, int c, bit t, bit e);
      vec_t v;
      v.rst = r; v.req = q; v.fid = f; v.cin = ci;
      v.g = g; v.x = x; v.c = c; v.t = t; v.e = e;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation did not finish, limit 1000000");
      $fatal(1, "time limit");
   end

   initial begin
      int hit, g_at, nx, to_seen, fi;
      model_reset();
      clear_in();
      fsel = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b110};
      pk   = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};

      // N packet, credit refill, overflow, simultaneous credit+transfer, reset.
      tbl[0]  = mk(0, 5'b00000, 15'h0000,             0, 1,  0, 4, 0, 0);
      tbl[1]  = mk(0, 5'b00010, 15'b000_000_000_001_000, 0, 1,  0, 4, 0, 0);
      tbl[2]  = mk(0, 5'b00010, 15'b000_000_000_001_000, 0, 4,  1, 4, 0, 0);
      tbl[3]  = mk(0, 5'b00010, 15'b000_000_000_010_000, 0, 4,  1, 3, 0, 0);
      tbl[4]  = mk(0, 5'b00010, 15'b000_000_000_100_000, 0, 4,  1, 2, 0, 0);
      tbl[5]  = mk(0, 5'b00000, 15'h0000,             0, 1,  0, 1, 0, 0);
      tbl[6]  = mk(0, 5'b00000, 15'h0000,             1, 1,  0, 1, 0, 0);
      tbl[7]  = mk(0, 5'b00000, 15'h0000,             1, 1,  0, 2, 0, 0);
      tbl[8]  = mk(0, 5'b00000, 15'h0000,             1, 1,  0, 3, 0, 0);
      tbl[9]  = mk(0, 5'b00000, 15'h0000,             1, 1,  0, 4, 0, 0);
      tbl[10] = mk(0, 5'b00001, 15'b000_000_000_000_001, 0, 1,  0, 4, 0, 1);
      tbl[11] = mk(0, 5'b00001, 15'b000_000_000_000_001, 1, 2,  1, 4, 0, 1);
      tbl[12] = mk(0, 5'b00001, 15'b000_000_000_000_100, 0, 2,  1, 4, 0, 1);
      tbl[13] = mk(0, 5'b00000, 15'h0000,             0, 1,  0, 3, 0, 1);
      tbl[14] = mk(1, 5'b00000, 15'h0000,             0, 1,  0, 3, 0, 1);
      tbl[15] = mk(0, 5'b00000, 15'h0000,             0, 1,  0, 4, 0, 0);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         d_rst = tbl[i].rst;
         d_req = tbl[i].req;
         for (int p = 0; p < 5; p++) d_fid[p] = tbl[i].fid[p*3 +: 3];
         d_cin = tbl[i].cin;
         cycle(1'b0, "tbl");
         check($sformatf("tbl[%0d].grant", i),      s_grant,      tbl[i].g);
         check($sformatf("tbl[%0d].flit_xfer", i),  int'(s_xfer), int'(tbl[i].x));
         check($sformatf("tbl[%0d].credits", i),    s_cred,       tbl[i].c);
         check($sformatf("tbl[%0d].timeout", i),    int'(s_to),   int'(tbl[i].t));
         check($sformatf("tbl[%0d].credit_err", i), int'(s_err),  int'(tbl[i].e));
      end

      // All five ports streaming single-flit packets: strict rotation, no bubbles.
      do_reset();
      d_req = 5'b11111;
      for (int p = 0; p < 5; p++) d_fid[p] = 3'b101;
      begin
         int exp_g [7] = '{1, 2, 4, 8, 16, 32, 2};
         for (int i = 0; i < 7; i++) begin
            d_cin = (i != 0);
            cycle(1'b1, "rot");
            check($sformatf("rot[%0d].grant_seq", i), s_grant, exp_g[i]);
         end
      end

      // Credit exhaustion on a 6-flit E packet: back-pressure is not a stall.
      do_reset();
      fi = 0; nx = 0; to_seen = 0;
      for (int i = 0; i < 25; i++) begin
         d_req[2] = (fi < 6);
         d_fid[2] = (fi < 6) ? pk[fi] : 3'b000;
         cycle(1'b1, "exh");
         if (s_xfer) nx++;
         if (s_to) to_seen++;
         if (mx) fi++;
      end
      check("exh.xfer_count", nx, 4);
      check("exh.grant_held", s_grant, 8);
      check("exh.no_timeout", to_seen, 0);
      d_cin = 1'b1;
      d_fid[2] = pk[fi];
      cycle(1'b1, "exh_cin");
      d_cin = 1'b0;
      nx = 0;
      for (int i = 0; i < 5; i++) begin
         d_req[2] = (fi < 6);
         d_fid[2] = (fi < 6) ? pk[fi] : 3'b000;
         cycle(1'b1, "exh2");
         if (s_xfer) nx++;
         if (mx) fi++;
      end
      check("exh.one_more_xfer", nx, 1);

      // Stall watchdog: W sends its head then goes quiet while S waits.
      do_reset();
      d_req[3] = 1'b1; d_fid[3] = 3'b001;
      cycle(1'b1, "stall_arb");
      cycle(1'b1, "stall_head");
      d_req[3] = 1'b0; d_fid[3] = 3'b000;
      d_req[4] = 1'b1; d_fid[4] = 3'b001;
      hit = -1; g_at = -1;
      for (int n = 0; n < 40; n++) begin
         cycle(1'b1, "stall");
         if (s_to) begin
            hit = n;
            g_at = s_grant;
            break;
         end
      end
      check("stall.timeout_cycle", hit, TIMEOUT);
      check("stall.grant_at_timeout", g_at, 1);
      cycle(1'b1, "stall_next");
      check("stall.s_granted", s_grant, 32);

      // Reset mid-packet while L owns the port with one credit left.
      do_reset();
      d_req[0] = 1'b1; d_fid[0] = 3'b001; d_cin = 1'b1;
      cycle(1'b1, "mid_arb");
      d_cin = 1'b0;
      cycle(1'b1, "mid_head");
      d_fid[0] = 3'b010;
      cycle(1'b1, "mid_body");
      cycle(1'b1, "mid_body");
      d_rst = 1'b1;
      cycle(1'b1, "mid_rst");
      check("mid.credits_before_rst", s_cred, 1);
      check("mid.no_xfer_in_rst", int'(s_xfer), 0);
      check("mid.err_before_rst", int'(s_err), 1);
      d_rst = 1'b0; d_fid[0] = 3'b001;
      cycle(1'b1, "mid_after");
      check("mid.grant_idle", s_grant, 1);
      check("mid.credits_restored", s_cred, CREDITS);
      check("mid.err_cleared", int'(s_err), 0);
      cycle(1'b1, "mid_regrant");
      check("mid.l_granted", s_grant, 2);

      // Randomized traffic in phases of differing request density.
      do_reset();
      for (int ph = 0; ph < 6; ph++) begin
         int prob;
         prob = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 40 : 8);
         for (int i = 0; i < 500; i++) begin
            d_rst = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 5; p++) begin
               d_req[p] = ($urandom_range(0, 99) < prob);
               d_fid[p] = fsel[$urandom_range(0, 5)];
            end
            d_cin = ($urandom_range(0, 99) < 35);
            cycle(1'b1, "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
